// File: rtl/fetch_block_pkg.sv
// Shared definitions for the instruction-fetch stage.
package fetch_block_pkg;

  localparam int WORD           = 32;
  localparam int INSTR_WIDTH    = 16;
  localparam int PC_STEP        = 2;
  localparam int PC_READ_OFFSET = 4;

  typedef enum logic {
    NO_STALL = 1'b0,
    STALL    = 1'b1
  } stall_pipeline_sig;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [WORD-1:0]        addr;
  } fetch_entry_t;

  // Thumb addresses are halfword aligned; bit 0 of a redirect is dropped.
  function automatic logic [WORD-1:0] align_halfword(input logic [WORD-1:0] addr);
    return {addr[WORD-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding slot for a memory response that arrives while decode is stalled.
module fetch_skid_buffer
  import fetch_block_pkg::*;
(
  input  logic         clk_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t entry_i,
  output fetch_entry_t entry_o,
  output logic         valid_o
);

  fetch_entry_t entry_q, entry_d;
  logic         valid_q, valid_d;

  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    if (flush_i) begin
      entry_d = '0;
      valid_d = 1'b0;
    end else if (push_i) begin
      entry_d = entry_i;
      valid_d = 1'b1;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk_i) begin
    entry_q <= entry_d;
    valid_q <= valid_d;
  end

  assign entry_o = entry_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_skid_checker.sv
// Protocol checks on the skid buffer handshake.
module fetch_skid_checker (
  input logic clk_i,
  input logic reset_i,
  input logic push_i,
  input logic pop_i,
  input logic valid_i,
  input logic flush_i
);

  a_no_push_and_pop: assert property (@(posedge clk_i) disable iff (reset_i)
    !(push_i && pop_i));

  // A second pending response would overwrite the first.
  a_no_overrun: assert property (@(posedge clk_i) disable iff (reset_i)
    !(push_i && valid_i && !flush_i));

endmodule

// File: rtl/fetch_block.sv
// Instruction-fetch stage: PC, synchronous imem request, and the fetch/decode register.
module fetch_block
  import fetch_block_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   stall_i,
  input  logic                   branch_taken_i,
  input  logic [WORD-1:0]        branch_target_i,
  input  logic [INSTR_WIDTH-1:0] imem_data_i,
  output logic                   imem_req_o,
  output logic [WORD-1:0]        imem_addr_o,
  output logic [INSTR_WIDTH-1:0] instruction_o,
  output logic [WORD-1:0]        program_counter_o,
  output logic                   is_valid_o
);

  stall_pipeline_sig      stall_s;
  logic                   req_s;
  logic [WORD-1:0]        addr_s;

  logic [WORD-1:0]        pc_q, pc_d;
  logic [WORD-1:0]        resp_addr_q, resp_addr_d;
  logic                   inflight_q, inflight_d;

  logic                   valid_q, valid_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [WORD-1:0]        pc_out_q, pc_out_d;

  logic                   skid_push_s, skid_pop_s, skid_flush_s, skid_valid_s;
  fetch_entry_t           skid_in_s, skid_out_s;

  // A branch always issues its target fetch, even while decode is stalled.
  always_comb begin
    stall_s = stall_pipeline_sig'(stall_i);
    addr_s  = branch_taken_i ? align_halfword(branch_target_i) : pc_q;
    req_s   = !reset_i && (branch_taken_i || (stall_s != STALL));
  end

  always_comb begin
    pc_d        = pc_q;
    resp_addr_d = resp_addr_q;
    inflight_d  = 1'b0;
    if (reset_i) begin
      pc_d        = RESET_PC;
      resp_addr_d = '0;
    end else if (req_s) begin
      pc_d        = addr_s + WORD'(PC_STEP);
      resp_addr_d = addr_s;
      inflight_d  = 1'b1;
    end else begin
      pc_d = pc_q;
    end
  end

  // F/D load priority: reset, branch squash, stall hold, then skid before live response.
  always_comb begin
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    skid_push_s  = 1'b0;
    skid_pop_s   = 1'b0;
    skid_flush_s = 1'b0;
    skid_in_s    = '{instr: imem_data_i, addr: resp_addr_q};
    if (reset_i) begin
      valid_d      = 1'b0;
      instr_d      = '0;
      pc_out_d     = '0;
      skid_flush_s = 1'b1;
    end else if (branch_taken_i) begin
      valid_d      = 1'b0;
      skid_flush_s = 1'b1;
    end else if (stall_s == STALL) begin
      skid_push_s = inflight_q;
    end else if (skid_valid_s) begin
      valid_d    = 1'b1;
      instr_d    = skid_out_s.instr;
      pc_out_d   = skid_out_s.addr + WORD'(PC_READ_OFFSET);
      skid_pop_s = 1'b1;
    end else if (inflight_q) begin
      valid_d  = 1'b1;
      instr_d  = imem_data_i;
      pc_out_d = resp_addr_q + WORD'(PC_READ_OFFSET);
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    pc_q        <= pc_d;
    resp_addr_q <= resp_addr_d;
    inflight_q  <= inflight_d;
    valid_q     <= valid_d;
    instr_q     <= instr_d;
    pc_out_q    <= pc_out_d;
  end

  fetch_skid_buffer u_skid (
    .clk_i   (clk_i),
    .push_i  (skid_push_s),
    .pop_i   (skid_pop_s),
    .flush_i (skid_flush_s),
    .entry_i (skid_in_s),
    .entry_o (skid_out_s),
    .valid_o (skid_valid_s)
  );

  fetch_skid_checker u_skid_chk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (skid_push_s),
    .pop_i   (skid_pop_s),
    .valid_i (skid_valid_s),
    .flush_i (skid_flush_s)
  );

  assign imem_req_o        = req_s;
  assign imem_addr_o       = addr_s;
  assign instruction_o     = instr_q;
  assign program_counter_o = pc_out_q;
  assign is_valid_o        = valid_q;

endmodule

// File: tb/tb_fetch_block.sv
// Randomized and directed bench for fetch_block against a queue-based fetch model.
module tb_fetch_block;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic [15:0] imem_data_i = 16'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [15:0] instruction_o;
  logic [31:0] program_counter_o;
  logic        is_valid_o;

  int checks = 0;
  int errors = 0;

  // Model: requested-but-not-returned addresses, and returned-but-not-delivered ones.
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_inflight[$];
  logic [31:0] m_held[$];
  logic [31:0] m_addr = 32'h0;
  bit          m_valid = 1'b0;
  bit          m_cleared = 1'b0;

  fetch_block #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .stall_i           (stall_i),
    .branch_taken_i    (branch_taken_i),
    .branch_target_i   (branch_target_i),
    .imem_data_i       (imem_data_i),
    .imem_req_o        (imem_req_o),
    .imem_addr_o       (imem_addr_o),
    .instruction_o     (instruction_o),
    .program_counter_o (program_counter_o),
    .is_valid_o        (is_valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem(input logic [31:0] a);
    return a[16:1] ^ a[31:16] ^ 16'h5A3C;
  endfunction

  always @(posedge clk) begin
    if (imem_req_o) imem_data_i <= mem(imem_addr_o);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit st, input bit br, input logic [31:0] tgt);
    bit          exp_req;
    logic [31:0] exp_addr;
    logic [31:0] arrived[$];
    reset_i = rst; stall_i = st; branch_taken_i = br; branch_target_i = tgt;
    exp_req  = !rst && (br || !st);
    exp_addr = br ? (tgt & 32'hFFFF_FFFE) : m_pc;
    #1;
    chk("imem_req", {31'b0, imem_req_o}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr_o, exp_addr);

    if (rst) begin
      m_pc = 32'h0;
      m_inflight.delete();
      m_held.delete();
      m_valid = 1'b0;
      m_cleared = 1'b1;
    end else begin
      arrived = m_inflight;
      m_inflight.delete();
      if (br) begin
        m_valid = 1'b0;
        m_held.delete();
      end else if (st) begin
        foreach (arrived[i]) m_held.push_back(arrived[i]);
      end else begin
        foreach (arrived[i]) m_held.push_back(arrived[i]);
        if (m_held.size() > 0) begin
          m_addr = m_held.pop_front();
          m_valid = 1'b1;
          m_cleared = 1'b0;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (exp_req) begin
        m_pc = exp_addr + 32'd2;
        m_inflight.push_back(exp_addr);
      end
    end

    @(posedge clk);
    #1;
    chk("is_valid", {31'b0, is_valid_o}, {31'b0, m_valid});
    if (m_valid) begin
      chk("instruction", {16'b0, instruction_o}, {16'b0, mem(m_addr)});
      chk("program_counter", program_counter_o, m_addr + 32'd4);
    end else if (m_cleared) begin
      chk("instruction_rst", {16'b0, instruction_o}, 32'h0);
      chk("program_counter_rst", program_counter_o, 32'h0);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset for two cycles, then straight-line fetch.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    run(4);
    // Stall while addr 6 is in flight; F/D holds addr 4.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    run(10);
    // Redirect to 0x100.
    step(1'b0, 1'b0, 1'b1, 32'h0000_0100);
    run(3);
    // Branch with stall while the skid is full.
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0201);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    run(3);
    // Reset in the middle of a stall with the skid full.
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0400);
    run(4);
    // Back-to-back branches, then PC wrap past the top of memory.
    step(1'b0, 1'b0, 1'b1, 32'h0000_0800);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0900);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFB);
    run(5);
    for (int i = 0; i < 600; i++) begin
      bit          r_rst, r_st, r_br;
      logic [31:0] r_tgt;
      r_rst = ($urandom_range(63) == 0);
      r_st  = ($urandom_range(3) == 0);
      r_br  = ($urandom_range(7) == 0);
      r_tgt = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_0FFF);
      step(r_rst, r_st, r_br, r_tgt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
